// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared opcodes, states and instruction layout
//
// Purpose: constants shared by instr_sequencer and seq_alu.
// Ports: none (package).
package instr_sequencer_pkg;

  // Instruction word layout
  localparam int INSTR_W  = 12;
  localparam int OP_W     = 4;
  localparam int OP_HI    = 11;
  localparam int OP_LO    = 8;
  localparam int DST_BIT  = 7;
  localparam int SRCA_BIT = 6;
  localparam int SRCB_BIT = 5;
  localparam int RSVD_BIT = 4;
  localparam int IMM_W    = 4;
  localparam int IMM_HI   = 3;
  localparam int IMM_LO   = 0;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_NOT = 4'd6,
    OP_LDI = 4'd7,
    OP_MOV = 4'd8,
    OP_SHL = 4'd9,
    OP_SHR = 4'd10,
    OP_INC = 4'd11
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  // Opcodes 1..11 produce a register write; 12..15 are unsupported.
  function automatic logic is_write_op(input logic [OP_W-1:0] op);
    return (op >= 4'd1) && (op <= 4'd11);
  endfunction

  function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
    return op >= 4'd12;
  endfunction

endpackage

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - combinational result and carry for the sequencer opcodes
//
// Purpose: computes the N-bit result and carry for one instruction.
// Ports:
//   op     - opcode
//   a, b   - operand registers
//   imm    - immediate field (LDI)
//   result - N-bit result, wraps modulo 2^N
//   carry  - carry/borrow/shifted-out bit, 0 for logic ops
module seq_alu
  import instr_sequencer_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [OP_W-1:0]  op,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [IMM_W-1:0] imm,
  output logic [N-1:0]     result,
  output logic             carry
);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_LDI: result = N'(imm);
      OP_MOV: result = a;
      OP_SHL: {carry, result} = {a, 1'b0};
      OP_SHR: {result, carry} = {1'b0, a};
      OP_INC: {carry, result} = {1'b0, a} + {{N{1'b0}}, 1'b1};
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - four-state instruction sequencer over a 2-entry register file
//
// Purpose: accepts one instruction at a time, reads two registers, executes
// through seq_alu and writes the result back with status flags.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   instr, instr_valid   - offered instruction
//   instr_ready          - high only in IDLE
//   SA, SB / A, B        - register-file read addresses / read data
//   D, DA, W             - write-back data, address, enable (W only in WRITE)
//   carry, zero          - registered flags, updated by writing ops
//   done, illegal        - one-cycle completion / unsupported-opcode pulses
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic               SA,
  output logic               SB,
  input  logic [N-1:0]       A,
  input  logic [N-1:0]       B,
  output logic [N-1:0]       D,
  output logic               DA,
  output logic               W,
  output logic               carry,
  output logic               zero,
  output logic               done,
  output logic               illegal
);

  state_e             state, state_nxt;
  logic [INSTR_W-1:0] ir;
  logic [N-1:0]       opa, opb;
  logic [N-1:0]       d_q;
  logic               da_q, carry_q, zero_q;
  logic [OP_W-1:0]    op;
  logic [N-1:0]       alu_res;
  logic               alu_carry;
  logic               unused_rsvd;

  assign op          = ir[OP_HI:OP_LO];
  assign unused_rsvd = ir[RSVD_BIT];

  // Read addresses come straight from the captured instruction, so they are
  // stable from READ onward and hold until the next capture.
  assign SA = ir[SRCA_BIT];
  assign SB = ir[SRCB_BIT];

  assign D     = d_q;
  assign DA    = da_q;
  assign carry = carry_q;
  assign zero  = zero_q;

  seq_alu #(.N(N)) u_alu (
    .op     (op),
    .a      (opa),
    .b      (opb),
    .imm    (ir[IMM_HI:IMM_LO]),
    .result (alu_res),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    W           = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_nxt = S_READ;
        end
      end
      S_READ: state_nxt = S_EXEC;
      S_EXEC: begin
        if (is_write_op(op)) begin
          state_nxt = S_WRITE;
        end else begin
          done      = 1'b1;
          illegal   = is_illegal_op(op);
          state_nxt = S_IDLE;
        end
      end
      S_WRITE: begin
        W         = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Write-back data and flags load on the EXEC->WRITE edge so they are
  // visible alongside W, and then hold until the next writing instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir      <= '0;
      opa     <= '0;
      opb     <= '0;
      d_q     <= '0;
      da_q    <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      if (state == S_IDLE && instr_valid) begin
        ir <= instr;
      end
      if (state == S_READ) begin
        opa <= A;
        opb <= B;
      end
      if (state == S_EXEC && is_write_op(op)) begin
        d_q     <= alu_res;
        da_q    <= ir[DST_BIT];
        carry_q <= alu_carry;
        zero_q  <= (alu_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        SA, SB, DA, W, carry, zero, done, illegal;
  logic [3:0]  A, B, D;

  logic [3:0] regs [2] = '{4'd0, 4'd0};

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_reg [2];
  int m_d, m_da, m_c, m_z;

  instr_sequencer #(.N(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .SA          (SA),
    .SB          (SB),
    .A           (A),
    .B           (B),
    .D           (D),
    .DA          (DA),
    .W           (W),
    .carry       (carry),
    .zero        (zero),
    .done        (done),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  assign A = regs[SA];
  assign B = regs[SB];

  always @(posedge clk) begin
    if (W) regs[DA] <= D;
  end

  typedef struct {
    logic [11:0] ins;
    logic        w;
    logic [3:0]  d;
    logic        da;
    logic        c;
    logic        z;
    logic        ill;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [11:0] mk(input int op, input int dst, input int sa, input int sb, input int imm);
    logic [3:0] o, im;
    o  = op[3:0];
    im = imm[3:0];
    return {o, dst[0], sa[0], sb[0], 1'b0, im};
  endfunction

  // Plain-arithmetic model: returns expected outputs seen at the done cycle.
  function automatic void model_step(input logic [11:0] ins, output logic w, output int d,
                                     output int da, output int c, output int z, output logic ill);
    int op, a, b, r, cc;
    op = int'(ins[11:8]);
    a  = m_reg[int'(ins[6])];
    b  = m_reg[int'(ins[5])];
    r  = 0;
    cc = 0;
    case (op)
      1:  begin r = a + b; cc = (r > 15) ? 1 : 0; end
      2:  begin r = a - b; cc = (a < b) ? 1 : 0; end
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  r = 15 - a;
      7:  r = int'(ins[3:0]);
      8:  r = a;
      9:  begin r = a * 2; cc = (a >= 8) ? 1 : 0; end
      10: begin r = a / 2; cc = a % 2; end
      11: begin r = a + 1; cc = (r > 15) ? 1 : 0; end
      default: r = 0;
    endcase
    r   = ((r % 16) + 16) % 16;
    w   = (op >= 1 && op <= 11);
    ill = (op >= 12);
    if (w) begin
      m_d  = r;
      m_da = int'(ins[7]);
      m_c  = cc;
      m_z  = (r == 0) ? 1 : 0;
      m_reg[int'(ins[7])] = r;
    end
    d  = m_d;
    da = m_da;
    c  = m_c;
    z  = m_z;
  endfunction

  // Issue one instruction from IDLE and observe it to completion.
  task automatic run_instr(input logic [11:0] ins, output int lat, output int wcnt,
                           output logic [3:0] d_s, output logic da_s, output logic c_s,
                           output logic z_s, output logic ill_s, output logic w_at_done);
    int k;
    logic seen;
    lat = 0; wcnt = 0; seen = 1'b0;
    d_s = 'x; da_s = 'x; c_s = 'x; z_s = 'x; ill_s = 'x; w_at_done = 'x;
    k = 0;
    while (!instr_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!instr_ready) chk("ready_timeout", 0, 1);
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (W) wcnt++;
      if (done) begin
        seen = 1'b1;
        lat = c;
        d_s = D; da_s = DA; c_s = carry; z_s = zero; ill_s = illegal; w_at_done = W;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge clk);
    if (W) wcnt++;
  endtask

  task automatic check_model(input logic [11:0] ins, input string tag);
    logic ew, eill, w_d;
    int ed, eda, ec, ez, lat, wcnt;
    logic [3:0] d_s;
    logic da_s, c_s, z_s, ill_s;
    model_step(ins, ew, ed, eda, ec, ez, eill);
    run_instr(ins, lat, wcnt, d_s, da_s, c_s, z_s, ill_s, w_d);
    chk({tag, "_lat"}, lat, ew ? 3 : 2);
    chk({tag, "_wcnt"}, wcnt, ew ? 1 : 0);
    chk({tag, "_w_at_done"}, w_d, ew);
    chk({tag, "_D"}, d_s, ed);
    chk({tag, "_DA"}, da_s, eda);
    chk({tag, "_carry"}, c_s, ec);
    chk({tag, "_zero"}, z_s, ez);
    chk({tag, "_illegal"}, ill_s, eill);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_W"}, W, 0);
    chk({tag, "_D"}, D, 0);
    chk({tag, "_DA"}, DA, 0);
    chk({tag, "_SA"}, SA, 0);
    chk({tag, "_SB"}, SB, 0);
    chk({tag, "_carry"}, carry, 0);
    chk({tag, "_zero"}, zero, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_illegal"}, illegal, 0);
    chk({tag, "_ready"}, instr_ready, 1);
  endtask

  initial begin
    logic ew, eill, w_d;
    int ed, eda, ec, ez, lat, wcnt, acc, wseen;
    logic [3:0] d_s;
    logic da_s, c_s, z_s, ill_s;
    logic [11:0] pat, exp_pat;

    // Directed vectors: {instr, W, D, DA, carry, zero, illegal} at the done cycle
    vecs[0]  = '{mk(7, 0, 0, 0, 5),  1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{mk(7, 1, 0, 0, 3),  1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{mk(1, 0, 0, 1, 0),  1'b1, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{mk(7, 0, 0, 0, 5),  1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{mk(2, 1, 1, 0, 0),  1'b1, 4'd14, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{mk(7, 0, 0, 0, 15), 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{mk(11, 0, 0, 0, 0), 1'b1, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{mk(7, 1, 0, 0, 1),  1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{mk(10, 1, 1, 0, 0), 1'b1, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{mk(13, 0, 1, 1, 9) | 12'h010, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{mk(0, 0, 0, 0, 0),  1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0};

    m_reg[0] = 0; m_reg[1] = 0;
    m_d = 0; m_da = 0; m_c = 0; m_z = 0;

    #2 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_reset", instr_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_instr(vecs[i].ins, lat, wcnt, d_s, da_s, c_s, z_s, ill_s, w_d);
      model_step(vecs[i].ins, ew, ed, eda, ec, ez, eill);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].w ? 3 : 2);
      chk($sformatf("vec%0d_wcnt", i), wcnt, vecs[i].w ? 1 : 0);
      chk($sformatf("vec%0d_w_at_done", i), w_d, vecs[i].w);
      chk($sformatf("vec%0d_D", i), d_s, vecs[i].d);
      chk($sformatf("vec%0d_DA", i), da_s, vecs[i].da);
      chk($sformatf("vec%0d_carry", i), c_s, vecs[i].c);
      chk($sformatf("vec%0d_zero", i), z_s, vecs[i].z);
      chk($sformatf("vec%0d_illegal", i), ill_s, vecs[i].ill);
    end

    // instr_valid held high: ready pattern 1,0,0,0 repeating, one accept per 4 cycles
    instr = mk(7, 1, 0, 0, 9);
    instr_valid = 1'b1;
    acc = 0; pat = '0;
    exp_pat = 12'b1000_1000_1000;
    for (int c = 0; c < 12; c++) begin
      pat[11 - c] = instr_ready;
      if (instr_ready) acc++;
      if (c < 11) @(negedge clk);
    end
    instr_valid = 1'b0;
    @(negedge clk);
    chk("hold_valid_ready_pattern", pat, exp_pat);
    chk("hold_valid_accepts", acc, 3);
    chk("hold_valid_R1", regs[1], 9);
    for (int k = 0; k < 3; k++) model_step(mk(7, 1, 0, 0, 9), ew, ed, eda, ec, ez, eill);

    // Put nonzero state on D/flags before the abort test
    check_model(mk(7, 0, 0, 0, 15), "pre_ldi");
    check_model(mk(1, 0, 0, 1, 0), "pre_add");

    // Reset during EXEC of an ADD: no W, reset values, register file untouched
    instr = mk(1, 1, 0, 1, 0);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wseen = W ? 1 : 0;
    rst = 1'b1;
    #1 check_reset_outputs("abort");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (W) wseen++;
    end
    rst = 1'b0;
    #1 chk("abort_ready_after", instr_ready, 1);
    @(negedge clk);
    if (W) wseen++;
    chk("abort_no_w", wseen, 0);
    chk("abort_R0_kept", regs[0], m_reg[0]);
    chk("abort_R1_kept", regs[1], m_reg[1]);
    m_d = 0; m_da = 0; m_c = 0; m_z = 0;

    // Randomized instructions against the model
    for (int i = 0; i < 40; i++) begin
      logic [11:0] r;
      r = 12'($urandom);
      check_model(r, $sformatf("rnd%0d", i));
    end
    chk("final_R0", regs[0], m_reg[0]);
    chk("final_R1", regs[1], m_reg[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter N, default 4, meaning the data width and matching the register-file bus width.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port instr, input, 12, instruction: [11:8] op, [7] dst, [6] srcA, [5] srcB, [4] reserved (ignored), [3:0] imm.
REQ-005 SHALL have port instr_valid, input, 1, instruction offered.
REQ-006 SHALL have port instr_ready, output, 1, sequencer can accept an instruction.
REQ-007 SHALL have port SA, output, 1, register-file A read address.
REQ-008 SHALL have port SB, output, 1, register-file B read address.
REQ-009 SHALL have port A, input, N, register-file A bus.
REQ-010 SHALL have port B, input, N, register-file B bus.
REQ-011 SHALL have port D, output, N, write-back data.
REQ-012 SHALL have port DA, output, 1, write-back destination address.
REQ-013 SHALL have port W, output, 1, write enable.
REQ-014 SHALL have ports carry, output, 1, and zero, output, 1, registered status flags.
REQ-015 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-016 SHALL have port illegal, output, 1, one-cycle pulse for an unsupported opcode.

Function
REQ-017 SHALL implement FSM states IDLE, READ, EXEC and WRITE.
REQ-018 SHALL drive instr_ready=1 only in IDLE.
REQ-019 SHALL capture instr on a clk edge where instr_valid and instr_ready are both 1, then go IDLE->READ.
REQ-020 SHALL leave instr_valid without effect outside IDLE; no queueing.
REQ-021 SHALL drive SA/SB from the captured srcA/srcB in READ and hold them in all states.
REQ-022 SHALL register A and B into operand registers at the end of READ, then go READ->EXEC.
REQ-023 SHALL compute result and flags from the operand registers in EXEC.
REQ-024 SHALL go EXEC->WRITE for writing ops; NOP and illegal ops SHALL go EXEC->IDLE with done=1 in EXEC and no W.
REQ-025 SHALL, in WRITE, drive W=1, D=result and DA=dst for exactly one cycle, pulse done, update carry/zero and return to IDLE.
REQ-026 SHALL give an accept-to-W latency of 3 clk edges: W is high in the 3rd cycle after acceptance, and the next instruction can be accepted in the cycle after WRITE.
REQ-027 SHALL use these opcodes: 0 NOP; 1 ADD A+B; 2 SUB A-B; 3 AND; 4 OR; 5 XOR; 6 NOT A; 7 LDI (D=imm, operands ignored); 8 MOV (D=A); 9 SHL A by 1 (zero fill); 10 SHR A by 1 (zero fill); 11 INC A+1.
REQ-028 SHALL treat opcodes 12-15 as illegal: pulse illegal together with done, no write, flags unchanged.
REQ-029 SHALL set carry as follows: ADD/INC = carry-out of the N+1-bit sum; SUB = borrow (1 when A<B unsigned); SHL = bit shifted out of MSB; SHR = bit shifted out of LSB; all others = 0.
REQ-030 SHALL set zero=1 when the N-bit result is 0; all arithmetic wraps modulo 2^N.
REQ-031 SHALL read the register state present before the write when srcA or srcB equals dst (read-modify-write is inherent).
REQ-032 SHALL hold W=0 in every state except WRITE.
REQ-033 SHALL hold D and DA at the last written values outside WRITE.

Reset
REQ-034 SHALL, on rst=1 and independent of clk, force state=IDLE and SA=SB=DA=0, D=0, W=0, carry=0, zero=0, done=0, illegal=0, operand and captured-instruction registers 0.
REQ-035 SHALL abort any in-flight instruction when reset is asserted mid-operation, with no W pulse issued.
REQ-036 SHALL drive instr_ready=1 in the first cycle after rst deasserts.

Structure
REQ-037 SHALL place opcode constants, state encoding, instruction field bit positions and instruction width (12) in a shared package.
REQ-038 SHALL implement result and carry computation in one combinational sub-module, seq_alu, instantiated once.
REQ-039 SHALL keep the FSM and the flag registers in instr_sequencer.

Verification
REQ-040 SHALL have a bench that instantiates instr_sequencer with the 2-register file and covers the scenarios below.
REQ-041 Reset then LDI R0,5 and LDI R1,3 -> W pulses with DA=0/D=5 and DA=1/D=3; 3-edge latency each; done coincident with W.
REQ-042 With R0=5, R1=3: ADD dst0 (srcA 0, srcB 1) -> D=8, carry=0, zero=0; then SUB dst1 (srcA 1, srcB 0) -> D=14, carry=1.
REQ-043 LDI R0,15 then INC R0 -> D=0, carry=1, zero=1; SHR of 1 -> D=0, carry=1.
REQ-044 Opcode 13 -> illegal and done pulse, W stays 0, flags unchanged; NOP -> done only, W stays 0.
REQ-045 instr_valid held high for 10 cycles -> instr_ready low in READ/EXEC/WRITE and exactly one acceptance per 4 cycles.
REQ-046 rst asserted in EXEC of ADD -> W never pulses, outputs return to reset values, and the register file holds its pre-instruction values.
